alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares one 8-bit `alu` datapath instance between NUM_REQ requesters.
- Each requester presents an opcode and two operands over a valid/ready handshake.
- The block grants one requester in round-robin order, sequences the operation through the ALU, registers the result, and returns it with the requester ID over a response handshake.
- Sits between requester blocks (SPI/IO front-ends, test sequencers) and the ALU inside the tt03 user design.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of requester ID; must equal clog2(NUM_REQ).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester request valid
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high
- req_op  input  4*NUM_REQ  opcode, requester i at [4i+3:4i]
- req_a  input  8*NUM_REQ  operand A, requester i at [8i+7:8i]
- req_b  input  8*NUM_REQ  operand B, requester i at [8i+7:8i]
- resp_valid  output  1  result valid
- resp_ready  input  1  consumer accepts result
- resp_data  output  8  ALU result
- resp_id  output  ID_W  index of the requester that issued the op
- busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (async assert, sync-clean deassert):
  - state=IDLE; resp_valid=0, resp_data=0, resp_id=0, busy=0, req_ready=0.
  - last_grant=NUM_REQ-1, so requester 0 has first priority.
- FSM states IDLE, EXEC, RESP.
- IDLE:
  - Grant g = first i with req_valid[i]=1, searching from last_grant+1 upward with modulo-NUM_REQ wrap.
  - req_ready[g]=1 combinationally in the same cycle; the handshake completes that cycle.
  - Latch op/A/B/g into internal registers; last_grant<=g; go to EXEC.
  - If no valid request, stay in IDLE with req_ready=0.
- EXEC (1 cycle):
  - The ALU is driven from the latched operands.
  - resp_data<=ALU Y; resp_id<=latched g; go to RESP.
- RESP:
  - resp_valid=1; resp_data and resp_id held stable.
  - On resp_valid&&resp_ready go to IDLE.
  - No req_ready in EXEC or RESP.
- Latency: request accepted at edge t gives resp_valid at t+2. Peak throughput is one op per 3 cycles with resp_ready tied high.
- Requesters must hold op/A/B stable while req_valid is high. Dropping valid before ready is allowed; that request is simply not granted.
- Arithmetic follows ALU semantics, 8-bit modulo wrap:
  - ADD 0xFF+0x01=0x00; SUB 0x00-0x01=0xFF; DEC 0x00=0xFF.
- Opcodes 1100..1111 are still accepted and return 0x00. They are never rejected.
- Simultaneous requests: exactly one grant per IDLE cycle. A requester that stays valid is served within NUM_REQ grants (starvation-free).
- Reset mid-operation (EXEC or RESP): the transaction is dropped, no response is produced, and the pointer is restored to its reset value.
- resp_data retains its last value after the response handshake.

Optional Feature:
- Macro ALU_ARB_FLAGS_EN.
- When defined:
  - Adds outputs resp_zero (1) and resp_neg (1), registered in EXEC alongside resp_data.
  - resp_zero = (Y==0); resp_neg = Y[7].
  - Both reset to 0 and are held during RESP.
- When undefined: the ports and registers are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg:
  - Opcode localparams: OP_ADD=4'h0, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR, OP_SHL4, OP_ROL, OP_ROR, OP_DEC, OP_INV=4'hB.
  - FSM state encoding: ST_IDLE=2'd0, ST_EXEC=2'd1, ST_RESP=2'd2.
- Sub-module rr_arbiter:
  - Purely combinational; takes req vector and last_grant, returns grant index plus any_valid.
  - The existing alu is instantiated directly.
- Top level holds the FSM, operand/result registers and port unpacking.

Test Plan:
- Single request: requester 2 valid with op=0000, A=0x3C, B=0x0F, resp_ready=1.
  - Expect req_ready[2] the same cycle; resp_valid 2 cycles later with resp_data=0x4B, resp_id=2.
- All four valid continuously after reset with different ops.
  - Expect grant order 0,1,2,3,0 and each resp_id matching its op's result.
- Fairness: req 0 and 3 permanently valid.
  - Expect grant/resp_id sequence 0,3,0,3; requesters 1 and 2 never granted.
- Backpressure: resp_ready=0 for 5 cycles while in RESP.
  - Expect resp_valid held, resp_data/resp_id stable, req_ready=0 throughout, busy=1.
  - After resp_ready=1, return to IDLE next cycle.
- Boundaries:
  - ADD 0xFF+0x01 gives 0x00 (resp_zero=1 with ALU_ARB_FLAGS_EN).
  - op=1111 gives 0x00.
  - ROL 0x81 gives 0x03.
  - DEC 0x00 gives 0xFF (resp_neg=1 with the macro).
- Async reset asserted during EXEC:
  - Expect resp_valid=0 immediately and no response for the dropped op.
  - After release, requester 0 is granted first when 0 and 1 are both valid.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the ALU arbiter slice.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_SHL4 = 4'h7;
    localparam logic [3:0] OP_ROL  = 4'h8;
    localparam logic [3:0] OP_ROR  = 4'h9;
    localparam logic [3:0] OP_DEC  = 4'hA;
    localparam logic [3:0] OP_INV  = 4'hB;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit ALU; shifts and rotates move operand A by one bit (SHL4 by four).
module alu
    import alu_pkg::*;
(
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    output logic [7:0] y
);

    always_comb begin
        y = 8'h00;
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_SHL:  y = {a[6:0], 1'b0};
            OP_SHR:  y = {1'b0, a[7:1]};
            OP_SHL4: y = {a[3:0], 4'h0};
            OP_ROL:  y = {a[6:0], a[7]};
            OP_ROR:  y = {a[0], a[7:1]};
            OP_DEC:  y = a - 8'h01;
            OP_INV:  y = ~a;
            // Reserved opcodes are accepted and simply yield zero.
            default: y = 8'h00;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester after last_grant, wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    last_grant,
    output logic [ID_W-1:0]    grant,
    output logic               any_valid
);

    logic [ID_W-1:0] idx;

    // Walk from the farthest candidate to the nearest so the nearest valid one wins.
    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (req[idx]) begin
                grant     = idx;
                any_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between NUM_REQ requesters (IDLE -> EXEC -> RESP).
// Define ALU_ARB_FLAGS_EN to add registered resp_zero/resp_neg result flags.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    output logic [NUM_REQ-1:0]   req_ready,
    input  logic [4*NUM_REQ-1:0] req_op,
    input  logic [8*NUM_REQ-1:0] req_a,
    input  logic [8*NUM_REQ-1:0] req_b,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [7:0]           resp_data,
    output logic [ID_W-1:0]      resp_id,
    output logic                 busy
`ifdef ALU_ARB_FLAGS_EN
    ,
    output logic                 resp_zero,
    output logic                 resp_neg
`endif
);

    state_t          state;
    state_t          state_next;
    logic [ID_W-1:0] grant;
    logic [ID_W-1:0] last_grant;
    logic [ID_W-1:0] lat_id;
    logic            any_valid;
    logic            accept;
    logic [3:0]      lat_op;
    logic [7:0]      lat_a;
    logic [7:0]      lat_b;
    logic [7:0]      alu_y;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant),
        .any_valid  (any_valid)
    );

    alu u_alu (
        .op (lat_op),
        .a  (lat_a),
        .b  (lat_b),
        .y  (alu_y)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The grant is only offered in IDLE; the handshake completes in the same cycle.
    always_comb begin
        state_next = state;
        req_ready  = '0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        busy       = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (any_valid) begin
                    req_ready[grant] = 1'b1;
                    accept           = 1'b1;
                    state_next       = ST_EXEC;
                end
            end
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Reset puts last_grant at the top index so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= ID_W'(NUM_REQ - 1);
            lat_id     <= '0;
            lat_op     <= '0;
            lat_a      <= '0;
            lat_b      <= '0;
            resp_data  <= '0;
            resp_id    <= '0;
`ifdef ALU_ARB_FLAGS_EN
            resp_zero  <= 1'b0;
            resp_neg   <= 1'b0;
`endif
        end else begin
            if (accept) begin
                lat_op     <= req_op[int'(grant)*4 +: 4];
                lat_a      <= req_a[int'(grant)*8 +: 8];
                lat_b      <= req_b[int'(grant)*8 +: 8];
                lat_id     <= grant;
                last_grant <= grant;
            end
            if (state == ST_EXEC) begin
                resp_data <= alu_y;
                resp_id   <= lat_id;
`ifdef ALU_ARB_FLAGS_EN
                resp_zero <= (alu_y == 8'h00);
                resp_neg  <= alu_y[7];
`endif
            end
        end
    end

endmodule
